spi_master_ctrl: RTL
====================

# spi_master_ctrl

Byte-oriented SPI master controller that generates SCLK, CS and MOSI and samples MISO for any of the four SPI modes. It sits between a parallel host (start/data/done handshake) and off-block SPI slaves, including our SPI slave block. It sequences single bytes or multi-byte bursts with CS held low, and derives SCLK from the system clock by a fixed divider.

## Interface
- CLK_DIV, 4: clk cycles per SCLK half-period; legal range 2..255
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  synchronous reset, active-low
- start  in  1  request one byte transfer; accepted only in IDLE or GAP
- mode  in  2  {CPOL, CPHA}; latched only on a start accepted in IDLE
- last  in  1  sampled with start; 1 = release CS after this byte
- tx_data  in  8  byte to send, MSB first; latched on accepted start
- busy  out  1  high in LEAD, SHIFT and TRAIL
- done  out  1  one-cycle pulse, byte complete
- rx_data  out  8  received byte; updated in the same cycle done is high, held otherwise
- SCLK  out  1  SPI clock
- CS  out  1  chip select, active-low
- MOSI  out  1  serial data out
- MISO  in  1  serial data in

## Operation
- States: IDLE, LEAD, SHIFT, GAP, TRAIL.
- IDLE: CS=1, MOSI=0, busy=0. The cpol register tracks mode[1] every cycle, so SCLK follows mode[1] one cycle late. On start, latch mode, last and tx_data, and go to LEAD.
- LEAD: CS=0 for CLK_DIV cycles. For CPHA=0, MOSI = tx bit7 from entry. For CPHA=1, MOSI is held at its previous value.
- SHIFT: runs 16 SCLK edges, indexed k=0..15. Even k is a leading edge; odd k is a trailing edge.
  - CPHA=0: sample MISO on leading edges. Update MOSI to the next bit on trailing edges k=1..13.
  - CPHA=1: update MOSI on leading edges, starting with bit7 at k=0. Sample MISO on trailing edges.
- Sampling: MISO is captured in the same clk cycle that drives the sampling edge. SCLK returns to CPOL after k=15.
- After k=15: done pulses and rx_data loads. If last=1, go to TRAIL. If last=0, go to GAP.
- GAP: CS=0, busy=0, SCLK=CPOL, MOSI holds. A start here latches tx_data and last and goes to LEAD. mode is ignored in GAP; the burst keeps the latched mode.
- TRAIL: CS=0 for CLK_DIV cycles, then go to IDLE and raise CS.
- start while busy=1 is ignored, with no side effects.
- Reset: rst_n=0 at any clk edge, including mid-byte, forces IDLE. Resulting values: CS=1, SCLK=0, MOSI=0, busy=0, done=0, rx_data=8'h00, cpol=0. A partial byte is discarded and no done is issued.

## Timing
- Start accepted at cycle t:
  - CS falls at t+1.
  - SCLK edge k at t+1+(k+1)*CLK_DIV.
  - done at t+2+16*CLK_DIV.
  - With last=1, CS rises at t+1+17*CLK_DIV.
- CLK_DIV=4: edges at t+5, t+9 … t+65, done at t+66, CS rises at t+69.
- A start accepted in GAP at cycle s produces its first edge at s+1+CLK_DIV.
- All outputs are registered; there is no combinational path from input to output.
- Half-period counter: 8 bits, counts 0..CLK_DIV-1 and wraps. Edge counter: 4 bits, wraps 15→0 on leaving SHIFT.

## Structure
- Package spi_pkg holds:
  - state enum
  - mode constants MODE0..MODE3 ({CPOL,CPHA})
  - BITS_PER_WORD=8
- Sub-module spi_clk_gen holds:
  - the half-period counter
  - the edge counter
  - SCLK toggle register
  - outputs tick, edge_idx, lead_edge
- spi_master_ctrl holds the FSM, shift registers and CS/MOSI/done logic.

## Test plan
- Mode 3, CLK_DIV=4, tx 8'hB3, last=1, MISO looped to MOSI:
  - MOSI bits 1,0,1,1,0,0,1,1 change on falling SCLK.
  - rx_data=8'hB3.
  - done at t+66, CS high at t+69.
- Mode 0, tx 8'hA5, with a slave model returning 8'h5A (driven on falling edges):
  - rx_data=8'h5A.
  - MOSI bit7 is valid at CS fall, before the first rising edge.
- Burst: 8'h11 with last=0, start in GAP 3 cycles after done, then 8'h22 with last=1:
  - CS stays low continuously.
  - Exactly two done pulses.
  - busy=0 during GAP.
- start pulsed mid-SHIFT with a different tx_data → ignored; the original byte completes unchanged. mode changed during GAP → SCLK polarity unchanged.
- rst_n=0 after SCLK edge 6:
  - Next cycle CS=1, SCLK=0, MOSI=0, busy=0, rx_data=8'h00.
  - No done is issued.
- Modes 1 and 2 with loopback, tx 8'h3C → rx 8'h3C. SCLK idles at CPOL before CS falls and after CS rises.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master controller.
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEAD,
        ST_SHIFT,
        ST_GAP,
        ST_TRAIL
    } state_t;

    // {CPOL, CPHA}
    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    localparam int BITS_PER_WORD = 8;

endpackage

// File: rtl/spi_master_ctrl_clk_gen.sv
// SCLK generator: half-period divider, SCLK edge counter and the SCLK register.
// The SCLK register doubles as the CPOL tracker while the controller is idle.
module spi_clk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,        // divider counts only while set, cleared otherwise
    input  logic       edge_en,    // produce an SCLK edge this cycle
    input  logic       idle_load,  // controller idle: SCLK follows cpol_in
    input  logic       cpol_in,
    output logic       tick,
    output logic [3:0] edge_idx,
    output logic       lead_edge,
    output logic       sclk
);

    localparam logic [7:0] DIV_M1 = 8'(CLK_DIV - 1);

    logic [7:0] cnt;

    assign tick      = run && (cnt == DIV_M1);
    assign lead_edge = ~edge_idx[0];

    // Half-period counter, 0..CLK_DIV-1, held at zero while not running.
    always_ff @(posedge clk) begin
        if (!rst_n || !run) cnt <= '0;
        else if (cnt == DIV_M1) cnt <= '0;
        else cnt <= cnt + 8'd1;
    end

    // Edge index k; sixteen edges per byte so it wraps back to zero on its own.
    always_ff @(posedge clk) begin
        if (!rst_n) edge_idx <= '0;
        else if (edge_en) edge_idx <= edge_idx + 4'd1;
    end

    // SCLK: tracks CPOL one cycle late when idle, toggles on each edge.
    always_ff @(posedge clk) begin
        if (!rst_n) sclk <= 1'b0;
        else if (idle_load) sclk <= cpol_in;
        else if (edge_en) sclk <= ~sclk;
    end

endmodule

// File: rtl/spi_master_ctrl.sv
// Byte-oriented SPI master: host start/done handshake, all four SPI modes,
// single bytes or CS-held bursts, SCLK from a fixed clk divider.
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [1:0] mode,
    input  logic       last,
    input  logic [7:0] tx_data,
    output logic       busy,
    output logic       done,
    output logic [7:0] rx_data,
    output logic       SCLK,
    output logic       CS,
    output logic       MOSI,
    input  logic       MISO
);

    state_t     state, state_nxt;
    logic       run;
    logic       tick, lead_edge;
    logic [3:0] edge_idx;
    logic       cpha, last_q, fin;
    logic [7:0] tx_sr, rx_sr;
    logic       accept, edge_en, sample, upd, mosi_bit;

    spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (run),
        .edge_en   (edge_en),
        .idle_load (state == ST_IDLE),
        .cpol_in   (mode[1]),
        .tick      (tick),
        .edge_idx  (edge_idx),
        .lead_edge (lead_edge),
        .sclk      (SCLK)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else state <= state_nxt;
    end

    // Next state plus edge/sample/shift strobes. Edge 0 is produced by the
    // tick that ends LEAD; edges 1..15 by the ticks in SHIFT.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        edge_en   = 1'b0;
        sample    = 1'b0;
        upd       = 1'b0;
        mosi_bit  = cpha ? tx_sr[7] : tx_sr[6];
        case (state)
            ST_IDLE: begin
                accept = start;
                if (start) state_nxt = ST_LEAD;
            end
            ST_LEAD: begin
                edge_en = tick;
                if (tick) state_nxt = ST_SHIFT;
            end
            ST_SHIFT: begin
                edge_en = tick;
                if (tick && edge_idx == 4'd15) state_nxt = last_q ? ST_TRAIL : ST_GAP;
            end
            ST_GAP: begin
                accept = start;
                if (start) state_nxt = ST_LEAD;
            end
            ST_TRAIL: begin
                if (tick) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (edge_en) begin
            sample = cpha ? ~lead_edge : lead_edge;
            // CPHA=0 presents bit7 in LEAD, so only trailing edges 1..13 advance it.
            upd    = cpha ? lead_edge : (~lead_edge && edge_idx != 4'd15);
        end
    end

    // Datapath: CS/MOSI/busy/done registers and the tx/rx shift registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run     <= 1'b0;
            busy    <= 1'b0;
            CS      <= 1'b1;
            MOSI    <= 1'b0;
            fin     <= 1'b0;
            done    <= 1'b0;
            rx_data <= 8'h00;
            rx_sr   <= 8'h00;
            tx_sr   <= 8'h00;
            cpha    <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            // run lags state by a cycle so LEAD spans CLK_DIV cycles of CS low.
            run  <= (state == ST_LEAD) || (state == ST_SHIFT) || (state == ST_TRAIL);
            busy <= (state_nxt == ST_LEAD) || (state_nxt == ST_SHIFT) ||
                    (state_nxt == ST_TRAIL);
            CS   <= (state == ST_IDLE) || (state == ST_TRAIL && tick);
            fin  <= edge_en && edge_idx == 4'd15;
            done <= fin;
            if (fin) rx_data <= rx_sr;
            if (accept) begin
                tx_sr  <= tx_data;
                last_q <= last;
                if (state == ST_IDLE) cpha <= mode[0];
            end else if (upd) begin
                tx_sr <= {tx_sr[6:0], 1'b0};
            end
            if (state == ST_IDLE) MOSI <= 1'b0;
            else if (state == ST_LEAD && !cpha) MOSI <= tx_sr[7];
            else if (upd) MOSI <= mosi_bit;
            if (sample) rx_sr <= {rx_sr[6:0], MISO};
        end
    end

endmodule
